seg7_counter_display: RTL

- Parametrised multi-digit counter that drives a bank of seven-segment displays.
- Each segment output is a 24-bit RGB colour word.
- It replaces the single-digit free-running bar controller with:
  - a configurable digit count and colours;
  - a programmable step rate;
  - up/down counting, hex or decimal mode, parallel load, and a wrap flag.
- It sits between the world clock and the display bar models.

---
 rtl/seg7_counter_display.sv | 133 +++++++++++++
 1 files changed

// File: rtl/seg7_counter_display.sv
// Multi-digit up/down hex/BCD counter with a programmable step prescaler,
// driving a bank of seven-segment displays as 24-bit RGB colour words.
module seg7_counter_display #(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned PRESCALE  = 4,
  parameter logic [23:0] COLOR_ON  = 24'hFF0000,
  parameter logic [23:0] COLOR_OFF = 24'h000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     up,
  input  logic                     hex_mode,
  input  logic                     load,
  input  logic [4*DIGITS-1:0]      load_value,
  output logic [4*DIGITS-1:0]      count,
  output logic                     tick,
  output logic                     wrap,
  output logic [DIGITS*7*24-1:0]   bars
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned BW = DIGITS * 7 * 24;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;
  logic [CW-1:0] next_count;
  logic          step_wrap;
  logic [BW-1:0] bars_next;
  logic [3:0]    dig;
  logic [3:0]    dig_next;
  logic          chain;
  logic          dig_carry;
  logic [6:0]    segs;

  // Lit-segment mask per nibble, bit s = segment s (a..g)
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

  // Ripple step: a digit moves only while every lower digit carried/borrowed
  always_comb begin
    next_count = count;
    chain      = 1'b1;
    dig        = 4'd0;
    dig_next   = 4'd0;
    dig_carry  = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig       = count[4*i +: 4];
      dig_next  = dig;
      dig_carry = 1'b0;
      if (up) begin
        if (hex_mode ? (dig == 4'hF) : (dig >= 4'd9)) begin
          dig_next  = 4'd0;
          dig_carry = 1'b1;
        end else begin
          dig_next = 4'(dig + 4'd1);
        end
      end else begin
        if (dig == 4'd0) begin
          dig_next  = hex_mode ? 4'hF : 4'd9;
          dig_carry = 1'b1;
        end else if (!hex_mode && dig > 4'd9) begin
          dig_next = 4'd9;
        end else begin
          dig_next = 4'(dig - 4'd1);
        end
      end
      if (chain) begin
        next_count[4*i +: 4] = dig_next;
        chain                = dig_carry;
      end
    end
    step_wrap = chain;
  end

  always_comb begin
    bars_next = '0;
    segs      = 7'd0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      segs = glyph(count[4*i +: 4]);
      for (int s = 0; s < 7; s++) begin
        bars_next[(7*i + s)*24 +: 24] = segs[s] ? COLOR_ON : COLOR_OFF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      count <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      bars  <= {(DIGITS*7){COLOR_OFF}};
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      bars <= bars_next;
      if (load) begin
        count <= load_value;
        presc <= '0;
      end else if (en) begin
        if (presc == PMAX) begin
          presc <= '0;
          count <= next_count;
          tick  <= 1'b1;
          wrap  <= step_wrap;
        end else begin
          presc <= PW'(presc + 1'b1);
        end
      end
    end
  end

endmodule
